// File: rtl/i2c_mem_slave.sv
// I2C target with a 2**AW-byte register file, auto-incrementing pointer, oversampled SCL/SDA.
// Latency: sda_oe updates three clk after the SCL edge reaches the pins; flow control is the I2C ACK/NACK bit.
module i2c_mem_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h50,
  parameter int         AW       = 4
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_pulse,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  state_t        state;
  logic          scl_m, scl_s, scl_p;
  logic          sda_m, sda_s, sda_p;
  logic          scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]    cnt;
  logic [6:0]    sh;
  logic [6:0]    tx;
  logic          ack_on;
  logic          rw;
  logic [AW-1:0] ptr;
  logic [7:0]    mem [2**AW];
  logic [7:0]    rx_byte;
  logic          last_bit;

  // Synchronisers reset to the idle bus level so release of reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      scl_m <= 1'b1; scl_s <= 1'b1; scl_p <= 1'b1;
      sda_m <= 1'b1; sda_s <= 1'b1; sda_p <= 1'b1;
    end else begin
      scl_m <= scl_i; scl_s <= scl_m; scl_p <= scl_s;
      sda_m <= sda_i; sda_s <= sda_m; sda_p <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;
  assign rx_byte   = {sh, sda_s};
  assign last_bit  = scl_rise && (cnt == 4'd7);
  assign dbg_data  = mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_pulse <= 1'b0;
      ptr      <= '0;
      cnt      <= 4'd0;
      sh       <= 7'd0;
      tx       <= 7'd0;
      ack_on   <= 1'b0;
      rw       <= 1'b0;
      for (int i = 0; i < 2**AW; i++) mem[i] <= 8'h00;
    end else begin
      wr_pulse <= 1'b0;
      if (state != IDLE && stop_det) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
      end else if (start_det) begin
        state  <= ADDR;
        busy   <= 1'b1;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        ack_on <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              sh  <= rx_byte[6:0];
              cnt <= last_bit ? 4'd0 : cnt + 4'd1;
            end
            if (last_bit) begin
              if (state == ADDR) begin
                rw    <= rx_byte[0];
                state <= (rx_byte[7:1] == DEV_ADDR) ? ADDR_ACK : WAIT_STOP;
              end else if (state == PTR) begin
                ptr   <= rx_byte[AW-1:0];
                state <= PTR_ACK;
              end else begin
                mem[ptr] <= rx_byte;
                wr_pulse <= 1'b1;
                ptr      <= ptr + 1'b1;
                state    <= WDATA_ACK;
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            // First falling edge drives the ACK, the second one ends the ACK clock.
            if (scl_fall) begin
              if (!ack_on) begin
                sda_oe <= 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                ack_on <= 1'b0;
                cnt    <= 4'd0;
                if (state == ADDR_ACK && rw) begin
                  tx     <= mem[ptr][6:0];
                  sda_oe <= ~mem[ptr][7];
                  cnt    <= 4'd1;
                  state  <= RDATA;
                end else if (state == ADDR_ACK) begin
                  state <= PTR;
                end else begin
                  state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr + 1'b1;
                state  <= RDATA_ACK;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[5:0], 1'b0};
                cnt    <= cnt + 4'd1;
              end
            end
          end
          RDATA_ACK: begin
            if (scl_rise && sda_s) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              tx     <= mem[ptr][6:0];
              sda_oe <= ~mem[ptr][7];
              cnt    <= 4'd1;
              state  <= RDATA;
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Directed bench for i2c_mem_slave: a bit-banged I2C master drives an open-drain bus model.
module tb_i2c_mem_slave;

  logic       clk = 1'b0;
  logic       Reset;
  logic       scl;
  logic       sda_m;
  logic       sda_line;
  logic       sda_oe;
  logic       busy;
  logic       wr_pulse;
  logic [3:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int oe_cnt   = 0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  i2c_mem_slave #(.DEV_ADDR(7'h50), .AW(4)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .scl_i    (scl),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_pulse (wr_pulse),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always @(posedge clk) begin
    if (wr_pulse) wr_cnt <= wr_cnt + 1;
    if (sda_oe)   oe_cnt <= oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b0; wait_clks(6);
    scl   = 1'b0; wait_clks(6);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wait_clks(6);
    scl   = 1'b1; wait_clks(6);
    sda_m = 1'b0; wait_clks(6);
    scl   = 1'b0; wait_clks(6);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(6);
    scl   = 1'b1; wait_clks(6);
    sda_m = 1'b1; wait_clks(6);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clks(6);
    scl   = 1'b1; wait_clks(8);
    scl   = 1'b0; wait_clks(6);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clks(6);
    scl   = 1'b1; wait_clks(4);
    ack   = ~sda_line;
    wait_clks(4);
    scl   = 1'b0; wait_clks(6);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d, output logic oe_in_ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wait_clks(6);
      scl   = 1'b1; wait_clks(4);
      d[i]  = sda_line;
      wait_clks(4);
      scl   = 1'b0; wait_clks(6);
    end
    sda_m = nack; wait_clks(6);
    scl   = 1'b1; wait_clks(4);
    oe_in_ack = sda_oe;
    wait_clks(4);
    scl   = 1'b0; wait_clks(6);
  endtask

  task automatic peek(input logic [3:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  initial begin
    logic       ack;
    logic       oe_ack;
    logic [7:0] d;
    int         wr0;
    int         oe0;

    Reset = 1'b0; scl = 1'b1; sda_m = 1'b1; dbg_addr = 4'd0;
    wait_clks(5);
    Reset = 1'b1;
    wait_clks(50);

    // Reset / idle bus
    check("reset_sda_oe", sda_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_pulse", wr_pulse, 0);
    for (int a = 0; a < 16; a++) begin
      peek(a[3:0], d);
      check($sformatf("reset_mem%0d", a), d, 8'h00);
    end

    // Write 0x5A, 0xC3 starting at pointer 3
    wr0 = wr_cnt;
    i2c_start();
    check("wr_busy_after_start", busy, 1);
    send_byte(8'hA0, ack); check("wr_addr_ack", ack, 1);
    send_byte(8'h03, ack); check("wr_ptr_ack", ack, 1);
    send_byte(8'h5A, ack); check("wr_d0_ack", ack, 1);
    send_byte(8'hC3, ack); check("wr_d1_ack", ack, 1);
    i2c_stop();
    check("wr_pulse_count", wr_cnt - wr0, 2);
    peek(4'd3, d); check("wr_mem3", d, 8'h5A);
    peek(4'd4, d); check("wr_mem4", d, 8'hC3);
    check("wr_busy_after_stop", busy, 0);

    // Set pointer, repeated START, read two bytes
    i2c_start();
    send_byte(8'hA0, ack); check("rd_addr_ack", ack, 1);
    send_byte(8'h03, ack); check("rd_ptr_ack", ack, 1);
    i2c_rstart();
    check("rd_busy_rstart", busy, 1);
    send_byte(8'hA1, ack); check("rd_raddr_ack", ack, 1);
    read_byte(1'b0, d, oe_ack);
    check("rd_byte0", d, 8'h5A);
    check("rd_oe_master_ack", oe_ack, 0);
    read_byte(1'b1, d, oe_ack);
    check("rd_byte1", d, 8'hC3);
    check("rd_oe_master_nack", oe_ack, 0);
    i2c_stop();
    check("rd_busy_after_stop", busy, 0);
    check("rd_oe_after_stop", sda_oe, 0);

    // Pointer wrap 15 -> 0
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("wrap_addr_ack", ack, 1);
    send_byte(8'h0F, ack); check("wrap_ptr_ack", ack, 1);
    send_byte(8'h11, ack); check("wrap_d0_ack", ack, 1);
    send_byte(8'h22, ack); check("wrap_d1_ack", ack, 1);
    i2c_stop();
    check("wrap_pulse_count", wr_cnt - wr0, 2);
    peek(4'd15, d); check("wrap_mem15", d, 8'h11);
    peek(4'd0, d);  check("wrap_mem0", d, 8'h22);

    // Wrong device address: never ACKs, writes nothing
    wr0 = wr_cnt; oe0 = oe_cnt;
    i2c_start();
    send_byte(8'hB0, ack); check("bad_addr_noack", ack, 0);
    send_byte(8'h33, ack); check("bad_data_noack", ack, 0);
    i2c_stop();
    check("bad_oe_never", oe_cnt - oe0, 0);
    check("bad_no_write", wr_cnt - wr0, 0);
    check("bad_busy_after_stop", busy, 0);
    peek(4'd3, d); check("bad_mem3_kept", d, 8'h5A);
    peek(4'd0, d); check("bad_mem0_kept", d, 8'h22);

    // STOP after a partial data byte discards it
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("part_addr_ack", ack, 1);
    send_byte(8'h07, ack); check("part_ptr_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    check("part_no_write", wr_cnt - wr0, 0);
    peek(4'd7, d); check("part_mem7", d, 8'h00);
    check("part_busy", busy, 0);

    // Reset in the middle of a data byte
    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("mid_addr_ack", ack, 1);
    send_byte(8'h05, ack); check("mid_ptr_ack", ack, 1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    Reset = 1'b0;
    wait_clks(1);
    check("mid_oe_released", sda_oe, 0);
    check("mid_busy_cleared", busy, 0);
    sda_m = 1'b1; scl = 1'b1;
    wait_clks(4);
    Reset = 1'b1;
    wait_clks(10);
    check("mid_no_write", wr_cnt - wr0, 0);
    peek(4'd3, d);  check("mid_mem3_cleared", d, 8'h00);
    peek(4'd15, d); check("mid_mem15_cleared", d, 8'h00);

    wr0 = wr_cnt;
    i2c_start();
    send_byte(8'hA0, ack); check("post_addr_ack", ack, 1);
    send_byte(8'h05, ack); check("post_ptr_ack", ack, 1);
    send_byte(8'h77, ack); check("post_d0_ack", ack, 1);
    i2c_stop();
    check("post_pulse_count", wr_cnt - wr0, 1);
    peek(4'd5, d); check("post_mem5", d, 8'h77);
    peek(4'd4, d); check("post_mem4", d, 8'h00);
    check("post_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
